// File: rtl/bus_pkg.sv
// Shared frame layout and receiver state encoding for the serial bus.
// The serializer uses the same constants, so both ends agree on field order and widths.
package bus_pkg;

    localparam int SRC_W      = 4;
    localparam int DST_W      = 4;
    localparam int DATA_W     = 64;
    localparam int CRC_W      = 4;
    localparam int FRAME_BITS = 1 + SRC_W + DST_W + DATA_W + CRC_W;

    localparam logic [3:0] CRC_POLY = 4'b0011;
    localparam logic [3:0] BCAST    = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        SRC,
        DST,
        DATA,
        CRC,
        CHECK
    } rx_state_t;

endpackage

// File: rtl/crc4_serial.sv
// Bit-serial CRC-4 (x^4+x+1) with an initial value of zero, one message bit per enabled cycle.
// clr has priority over en, so the receiver can hold the register at zero while it waits for a frame.
module crc4_serial
    import bus_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [3:0] crc
);

    logic [3:0] crc_reg;
    logic       feedback;

    assign feedback = crc_reg[3] ^ bit_in;

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            crc_reg <= 4'b0000;
        end else if (en) begin
            crc_reg <= {crc_reg[2:0], 1'b0} ^ (feedback ? CRC_POLY : 4'b0000);
        end
    end

    assign crc = crc_reg;

endmodule

// File: rtl/bus_frame_receiver.sv
// Serial frame receiver: parses START|SRC|DST|DATA|CRC, checks the CRC and the destination address,
// and presents accepted payloads through a single valid/ready holding register.
module bus_frame_receiver #(
    parameter logic [3:0] MY_ADDR = 4'd1,
    parameter logic [3:0] BCAST   = 4'hF,
    parameter int         DATA_W  = 64,
    parameter int         CRC_W   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              bus_in,
    input  logic              rx_ready,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic [3:0]        rx_src,
    output logic              crc_err,
    output logic              overflow,
    output logic              busy
);
    // Explicit imports keep the package constants from colliding with this module's parameters.
    import bus_pkg::rx_state_t;
    import bus_pkg::IDLE;
    import bus_pkg::SRC;
    import bus_pkg::DST;
    import bus_pkg::DATA;
    import bus_pkg::CRC;
    import bus_pkg::CHECK;

    rx_state_t          state_reg, state_next;
    logic [6:0]         bit_cnt_reg;
    logic [3:0]         src_sr_reg;
    logic [3:0]         dst_sr_reg;
    logic [DATA_W-1:0]  data_sr_reg;
    logic [CRC_W-1:0]   crc_sr_reg;
    logic               rx_valid_reg;
    logic [DATA_W-1:0]  rx_data_reg;
    logic [3:0]         rx_src_reg;

    logic               crc_clr, crc_en, load, addr_hit;
    logic [3:0]         crc_calc;

    crc4_serial u_crc (
        .clock  (clock),
        .reset  (reset),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (bus_in),
        .crc    (crc_calc)
    );

    assign addr_hit = (dst_sr_reg == MY_ADDR) || (dst_sr_reg == BCAST);

    always_comb begin
        state_next = state_reg;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;
        load       = 1'b0;
        crc_err    = 1'b0;
        overflow   = 1'b0;
        busy       = 1'b1;
        case (state_reg)
            IDLE: begin
                crc_clr = 1'b1;
                busy    = bus_in;
                if (bus_in) state_next = SRC;
            end
            SRC: begin
                if (bit_cnt_reg == 7'd3) state_next = DST;
            end
            DST: begin
                crc_en = 1'b1;
                if (bit_cnt_reg == 7'd3) state_next = DATA;
            end
            DATA: begin
                crc_en = 1'b1;
                if (bit_cnt_reg == 7'(DATA_W - 1)) state_next = CRC;
            end
            CRC: begin
                if (bit_cnt_reg == 7'(CRC_W - 1)) state_next = CHECK;
            end
            CHECK: begin
                state_next = IDLE;
                // Address miss is silent; otherwise CRC error beats overflow.
                if (addr_hit) begin
                    if (crc_calc != crc_sr_reg)        crc_err  = 1'b1;
                    else if (rx_valid_reg && !rx_ready) overflow = 1'b1;
                    else                               load     = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                busy       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= 7'd0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= (state_next != state_reg) ? 7'd0 : bit_cnt_reg + 7'd1;
        end
    end

    always_ff @(posedge clock) begin
        case (state_reg)
            SRC:     src_sr_reg  <= {src_sr_reg[2:0], bus_in};
            DST:     dst_sr_reg  <= {dst_sr_reg[2:0], bus_in};
            DATA:    data_sr_reg <= {data_sr_reg[DATA_W-2:0], bus_in};
            CRC:     crc_sr_reg  <= {crc_sr_reg[CRC_W-2:0], bus_in};
            default: ;
        endcase
    end

    // A pop and a load in the same cycle leave rx_valid high with the new frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_valid_reg <= 1'b0;
            rx_data_reg  <= '0;
            rx_src_reg   <= 4'd0;
        end else if (load) begin
            rx_valid_reg <= 1'b1;
            rx_data_reg  <= data_sr_reg;
            rx_src_reg   <= src_sr_reg;
        end else if (rx_valid_reg && rx_ready) begin
            rx_valid_reg <= 1'b0;
        end
    end

    assign rx_valid = rx_valid_reg;
    assign rx_data  = rx_data_reg;
    assign rx_src   = rx_src_reg;

endmodule
